// File: rtl/gray_trk_pkg.sv
// Shared types and helpers for the circular Gray-code position tracker.
// Defaults, step-direction encoding and the Gray-to-binary decode.
package gray_trk_pkg;

  localparam int GT_WIDTH  = 3;
  localparam int GT_STABLE = 4;
  localparam int GT_SYNC   = 2;
  localparam int GT_REV_W  = 8;
  localparam int GT_MAX_W  = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // XOR prefix from the MSB; leading zeros decode to zeros.
  function automatic logic [GT_MAX_W-1:0] gray2bin(
    input logic [GT_MAX_W-1:0] g
  );
    logic [GT_MAX_W-1:0] b;
    b[GT_MAX_W-1] = g[GT_MAX_W-1];
    for (int i = GT_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder of parametrised width.
// Zero-extends into the shared 8-bit decoder and keeps the low bits.
module gray_to_bin
  import gray_trk_pkg::*;
#(
  parameter int WIDTH = GT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Decode through the package function.
  always_comb begin
    bin_o = WIDTH'(gray2bin(GT_MAX_W'(gray_i)));
  end

endmodule

// File: rtl/gray_position_tracker.sv
// Synchronised, debounced circular Gray position tracker.
// Reports single steps, direction, revolutions and illegal jumps.
module gray_position_tracker
  import gray_trk_pkg::*;
#(
  parameter int WIDTH         = GT_WIDTH,
  parameter int STABLE_CYCLES = GT_STABLE,
  parameter int SYNC_STAGES   = GT_SYNC,
  parameter int REV_W         = GT_REV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] code_in,
  output logic [WIDTH-1:0] pos_out,
  output logic             step_valid,
  output logic             step_dir,
  output logic [REV_W-1:0] rev_count,
  output logic             err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] D_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] D_DN = '1;
  localparam logic [WIDTH-1:0] P_MAX = '1;
  localparam logic [WIDTH-1:0] P_MIN = '0;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qualify;

  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] diff;

  logic             primed_q, primed_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             sv_q, sv_d;
  dir_e             dir_q, dir_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             err_q, err_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Input synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], code_in};
    end
  end

  // Debounce: track candidate code and its stable run length.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync_last != cand_q) begin
      cand_d = sync_last;
      cnt_d  = '0;
    end else if (!en) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Qualify fires on the edge where the run reaches its target.
  assign qualify = en && (sync_last == cand_q)
                && (cnt_q == CNT_PRE);

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray_i(cand_q),
    .bin_o (bin_new)
  );

  assign diff = bin_new - pos_q;

  // Step classification, revolution tracking and clear.
  always_comb begin
    primed_d = primed_q;
    pos_d    = pos_q;
    sv_d     = 1'b0;
    dir_d    = dir_q;
    rev_d    = rev_q;
    err_d    = err_q;
    if (qualify) begin
      if (!primed_q) begin
        pos_d    = bin_new;
        primed_d = 1'b1;
      end else if (diff == D_UP) begin
        pos_d = bin_new;
        sv_d  = 1'b1;
        dir_d = DIR_UP;
        if (pos_q == P_MAX) rev_d = rev_q + REV_W'(1);
      end else if (diff == D_DN) begin
        pos_d = bin_new;
        sv_d  = 1'b1;
        dir_d = DIR_DOWN;
        if (pos_q == P_MIN) rev_d = rev_q - REV_W'(1);
      end else if (diff != '0) begin
        pos_d = bin_new;
        err_d = 1'b1;
      end
    end
    if (clear) begin
      rev_d = '0;
      err_d = 1'b0;
    end
  end

  // Debounce and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      pos_q    <= '0;
      sv_q     <= 1'b0;
      dir_q    <= DIR_DOWN;
      rev_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      sv_q     <= sv_d;
      dir_q    <= dir_d;
      rev_q    <= rev_d;
      err_q    <= err_d;
    end
  end

  assign pos_out    = pos_q;
  assign step_valid = sv_q;
  assign step_dir   = dir_q;
  assign rev_count  = rev_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gray_position_tracker.sv
// Self-checking bench for gray_position_tracker (default parameters).
// Expected step pulses are queued and matched by a pulse monitor.
module tb_gray_position_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       clear = 1'b0;
  logic [2:0] code_in = 3'b000;
  logic [2:0] pos_out;
  logic       step_valid;
  logic       step_dir;
  logic [7:0] rev_count;
  logic       err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] pos;
    logic       dir;
    logic [7:0] rev;
  } exp_t;

  exp_t exq[$];

  gray_position_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .code_in   (code_in),
    .pos_out   (pos_out),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .rev_count (rev_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: every step_valid must match a queued expectation.
  always @(negedge clk) begin
    if (step_valid) begin
      checks++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pos=%0d dir=%0d rev=%0d, required no pulse",
                 pos_out, step_dir, rev_count);
      end else begin
        exp_t e;
        e = exq.pop_front();
        if (pos_out !== e.pos || step_dir !== e.dir || rev_count !== e.rev) begin
          errors++;
          $display("FAIL step_pulse: pos=%0d dir=%0d rev=%h, required pos=%0d dir=%0d rev=%h",
                   pos_out, step_dir, rev_count, e.pos, e.dir, e.rev);
        end
      end
    end
  end

  task automatic push(input logic [2:0] p, input logic d, input logic [7:0] r);
    exp_t e;
    e.pos = p;
    e.dir = d;
    e.rev = r;
    exq.push_back(e);
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    code_in = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_prime(input logic [2:0] c);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    clear = 1'b0;
    code_in = c;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic queue_drained(input string name);
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d pulses missing, required 0", name, exq.size());
      exq.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b1;
    code_in = 3'b110;
    repeat (3) @(negedge clk);
    checks++;
    if ({pos_out, step_valid, step_dir, rev_count, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: pos=%0d sv=%0d dir=%0d rev=%h err=%0d, required all 0",
               pos_out, step_valid, step_dir, rev_count, err);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (pos_out !== ((i == 7) ? 3'd4 : 3'd0)) begin
        errors++;
        $display("FAIL latency_edge%0d: pos=%0d, required %0d",
                 i, pos_out, (i == 7) ? 4 : 0);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL first_load_err: err=%0d, required 0", err);
    end
    queue_drained("reset");
  endtask

  task automatic test_up_sequence;
    logic [2:0] seq [8];
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    reset_prime(3'b000);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      p = 3'((i + 1) % 8);
      push(p, 1'b1, (i == 7) ? 8'd1 : 8'd0);
      hold(seq[i], 10);
      checks++;
      if (pos_out !== p) begin
        errors++;
        $display("FAIL up_pos%0d: pos=%0d, required %0d", i, pos_out, p);
      end
    end
    checks++;
    if (rev_count !== 8'd1) begin
      errors++;
      $display("FAIL up_rev: rev=%h, required 01", rev_count);
    end
    queue_drained("up");
  endtask

  task automatic test_down_wrap;
    reset_prime(3'b000);
    push(3'd7, 1'b0, 8'hFF);
    hold(3'b100, 12);
    checks++;
    if (pos_out !== 3'd7 || rev_count !== 8'hFF || err !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap: pos=%0d rev=%h err=%0d, required 7 FF 0",
               pos_out, rev_count, err);
    end
    queue_drained("down");
  endtask

  task automatic test_glitch_enable;
    reset_prime(3'b000);
    hold(3'b011, 3);
    hold(3'b000, 15);
    checks++;
    if (pos_out !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL glitch: pos=%0d err=%0d, required 0 0", pos_out, err);
    end
    en = 1'b0;
    hold(3'b011, 20);
    checks++;
    if (pos_out !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL en_off: pos=%0d err=%0d, required 0 0", pos_out, err);
    end
    hold(3'b000, 5);
    en = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pos_out !== 3'd0) begin
      errors++;
      $display("FAIL en_back: pos=%0d, required 0", pos_out);
    end
    queue_drained("glitch");
  endtask

  task automatic test_jump_clear;
    reset_prime(3'b000);
    hold(3'b011, 12);
    checks++;
    if (pos_out !== 3'd2 || err !== 1'b1 || rev_count !== 8'd0) begin
      errors++;
      $display("FAIL jump: pos=%0d err=%0d rev=%h, required 2 1 00",
               pos_out, err, rev_count);
    end
    reset_prime(3'b000);
    push(3'd7, 1'b0, 8'hFF);
    hold(3'b100, 12);
    hold(3'b010, 12);
    checks++;
    if (pos_out !== 3'd3 || err !== 1'b1 || rev_count !== 8'hFF) begin
      errors++;
      $display("FAIL jump_rev: pos=%0d err=%0d rev=%h, required 3 1 FF",
               pos_out, err, rev_count);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (pos_out !== 3'd3 || err !== 1'b0 || rev_count !== 8'd0) begin
      errors++;
      $display("FAIL clear: pos=%0d err=%0d rev=%h, required 3 0 00",
               pos_out, err, rev_count);
    end
    queue_drained("jump");
  endtask

  task automatic test_clear_priority;
    reset_prime(3'b100);
    push(3'd0, 1'b1, 8'd0);
    code_in = 3'b000;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pos_out !== 3'd0 || rev_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_prio: pos=%0d rev=%h, required 0 00", pos_out, rev_count);
    end
    queue_drained("clrprio");
  endtask

  task automatic test_reset_mid;
    reset_prime(3'b000);
    push(3'd7, 1'b0, 8'hFF);
    hold(3'b100, 12);
    code_in = 3'b101;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pos_out, step_valid, step_dir, rev_count, err} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: pos=%0d sv=%0d dir=%0d rev=%h err=%0d, required all 0",
               pos_out, step_valid, step_dir, rev_count, err);
    end
    code_in = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (pos_out !== ((i == 7) ? 3'd3 : 3'd0)) begin
        errors++;
        $display("FAIL reload_edge%0d: pos=%0d, required %0d",
                 i, pos_out, (i == 7) ? 3 : 0);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reload_err: err=%0d, required 0", err);
    end
    queue_drained("rstmid");
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_glitch_enable();
    test_jump_clear();
    test_clear_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_position_tracker.md
Name: gray_position_tracker

Overview:
Parametrised successor to the combinational circular-code decoders. Samples a WIDTH-bit circular Gray-coded position (rotary/absolute encoder, ring selector) and synchronises and debounces it. Decodes it to binary and tracks step direction, full-revolution count and illegal multi-step jumps. Sits between raw pad inputs and the datapath/display logic.

Parameters:
WIDTH, 3, Gray code width; legal range 2..8; positions 0..2^WIDTH-1.
STABLE_CYCLES, 4, consecutive identical synchronised samples required to qualify a code; legal range 1..255.
SYNC_STAGES, 2, flip-flops in the input synchroniser; minimum 2.
REV_W, 8, width of the signed revolution counter.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  qualification enable.
clear  in  1  synchronous clear of rev_count and err.
code_in  in  WIDTH  raw circular Gray code.
pos_out  out  WIDTH  decoded binary position, registered.
step_valid  out  1  one-cycle pulse per legal single step.
step_dir  out  1  direction of last step: 1 = up (+1), 0 = down (-1).
rev_count  out  REV_W  signed two's-complement revolution count.
err  out  1  sticky illegal-jump flag.

Behaviour:
- Reset (asynchronous, rst_n=0): all registers cleared, including synchroniser, candidate, counter, primed flag and all outputs (pos_out=0, step_valid=0, step_dir=0, rev_count=0, err=0). Takes effect immediately, including mid-debounce.
- Synchroniser: SYNC_STAGES flip-flop chain; its last stage is sync_q.
- Debounce:
  - cand register and cnt counter (saturates at STABLE_CYCLES).
  - If sync_q != cand: cand<=sync_q, cnt<=0.
  - Else if en=1 and cnt<STABLE_CYCLES: cnt+1.
  - When cnt transitions to STABLE_CYCLES, a "qualify" event fires for one cycle.
  - en=0: cnt held at 0 and no qualify. After en returns to 1, a full STABLE_CYCLES is required.
- Latency: code_in stable before edge 0 gives pos_out/step_valid updated after edge SYNC_STAGES+STABLE_CYCLES+1. Default is 7 edges.
- On qualify, with primed=0 (first qualify after reset): pos_out<=gray2bin(cand), primed<=1, no step_valid, no err, rev_count unchanged.
- On qualify, with primed=1:
  - Compute b_new=gray2bin(cand), b_old=pos_out, d=(b_new-b_old) mod 2^WIDTH.
  - d=0: no action.
  - d=1: pos_out<=b_new, step_valid=1, step_dir=1. If b_old=2^WIDTH-1 (wrap to 0), rev_count+1.
  - d=2^WIDTH-1: pos_out<=b_new, step_valid=1, step_dir=0. If b_old=0 (wrap to max), rev_count-1.
  - Any other d: pos_out<=b_new, err<=1 (sticky), no step_valid, rev_count unchanged. For WIDTH=2, d=2 is an error.
- rev_count wraps modulo 2^REV_W (127+1 gives -128).
- step_valid is high exactly one cycle, on the same edge pos_out updates. step_dir holds its last value.
- clear=1: rev_count<=0 and err<=0 at the next edge. pos_out, primed and the debounce state are unaffected.
  - Clear has priority over a simultaneous wrap increment/decrement: rev_count=0.
  - Clear has priority over a simultaneous err set: err=0.
  - A simultaneous step_valid pulse still fires.
- No combinational path from any input to any output.

Decomposition:
- Package gray_trk_pkg holds:
  - localparams for default WIDTH/STABLE_CYCLES/SYNC_STAGES/REV_W;
  - a parametrised gray2bin function (XOR prefix from the MSB);
  - an enum for step_dir (DIR_DOWN=0, DIR_UP=1).
- One sub-module is natural: gray_to_bin (parameter WIDTH, purely combinational), instantiated once on cand. The synchroniser stays inline.

Test Plan:
1. Reset, then code_in=3'b110 held → pos_out=4 exactly 7 edges after release; step_valid never pulses; err=0.
2. After initial 000, sequence 001,011,010,110,111,101,100,000, each held 10 cycles → pos_out 1..7 then 0, eight step_valid pulses with step_dir=1, rev_count=1 after the final step.
3. From primed 000, apply 100 → pos_out=7, one pulse with step_dir=0, rev_count=8'hFF (-1).
4. From primed 000, apply 011 for 3 cycles then 000 → no qualify, pos_out=0, no pulse. Repeat with en=0 and 011 held 20 cycles → no change.
5. From primed 000, apply 011 → pos_out=2, err=1, no pulse, rev_count unchanged. Pulse clear → err=0, rev_count=0, pos_out stays 2.
6. Drop rst_n mid-debounce (cnt=2) → all outputs 0 immediately. After release with code_in=010 → initial load pos_out=3, no pulse, no err.
